// File: rtl/control_pipeline.sv
// E/M/W control pipeline: gates E-stage controls with the ARM condition check
// against a local NZCV register and holds E for multi-cycle (MUL-class) ops.
module control_pipeline #(
    parameter int ALUCTRL_W = 4,
    parameter int MUL_LAT   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 PCSrcD,
    input  logic                 RegWriteD,
    input  logic                 MemtoRegD,
    input  logic                 MemWriteD,
    input  logic                 BranchD,
    input  logic                 ALUSrcD,
    input  logic [ALUCTRL_W-1:0] ALUControlD,
    input  logic [1:0]           FlagWriteD,
    input  logic [3:0]           CondD,
    input  logic                 MulD,
    input  logic                 FlushE,
    input  logic [3:0]           ALUFlags,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 ALUSrcE,
    output logic                 CondExE,
    output logic                 BranchTakenE,
    output logic                 BusyE,
    output logic                 RegWriteM,
    output logic                 MemWriteM,
    output logic                 MemtoRegM,
    output logic                 RegWriteW,
    output logic                 MemtoRegW,
    output logic                 PCSrcW,
    output logic [3:0]           Flags
);

    localparam logic       MUL_EN   = (MUL_LAT > 1);
    localparam logic [3:0] CNT_INIT = (MUL_LAT > 1) ? 4'(MUL_LAT - 2) : 4'd0;

    typedef enum logic {IDLE, BUSY} stateT;

    stateT      state;
    logic [3:0] cnt;

    logic       pcSrcE, regWriteE, memtoRegE, memWriteE, branchE, mulE;
    logic [1:0] flagWriteE;
    logic [3:0] condE;
    logic       pcSrcM;

    logic       regWriteEg, memWriteEg, pcSrcEg;
    logic [1:0] flagWriteEg;
    logic       startBusy;

    function automatic logic condCheck(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            4'b0000: condCheck = z;
            4'b0001: condCheck = !z;
            4'b0010: condCheck = c;
            4'b0011: condCheck = !c;
            4'b0100: condCheck = n;
            4'b0101: condCheck = !n;
            4'b0110: condCheck = v;
            4'b0111: condCheck = !v;
            4'b1000: condCheck = c & !z;
            4'b1001: condCheck = !c | z;
            4'b1010: condCheck = (n == v);
            4'b1011: condCheck = (n != v);
            4'b1100: condCheck = !z & (n == v);
            4'b1101: condCheck = z | (n != v);
            4'b1110: condCheck = 1'b1;
            default: condCheck = 1'b0;
        endcase
    endfunction

    assign CondExE      = condCheck(condE, Flags);
    assign BranchTakenE = branchE & CondExE;
    assign regWriteEg   = regWriteE & CondExE;
    assign memWriteEg   = memWriteE & CondExE;
    assign pcSrcEg      = pcSrcE & CondExE;
    assign flagWriteEg  = flagWriteE & {2{CondExE}};

    // BusyE deliberately ignores FlushE: a flushed op still bubbles M this cycle
    assign startBusy = (state == IDLE) && mulE && CondExE && MUL_EN;
    assign BusyE     = startBusy || ((state == BUSY) && (cnt != 4'd0));

    // D -> E
    always_ff @(posedge clk or negedge reset) begin
        if (!reset || FlushE) begin
            pcSrcE      <= 1'b0;
            regWriteE   <= 1'b0;
            memtoRegE   <= 1'b0;
            memWriteE   <= 1'b0;
            branchE     <= 1'b0;
            ALUSrcE     <= 1'b0;
            ALUControlE <= '0;
            flagWriteE  <= 2'b00;
            condE       <= 4'd0;
            mulE        <= 1'b0;
        end else if (!BusyE) begin
            pcSrcE      <= PCSrcD;
            regWriteE   <= RegWriteD;
            memtoRegE   <= MemtoRegD;
            memWriteE   <= MemWriteD;
            branchE     <= BranchD;
            ALUSrcE     <= ALUSrcD;
            ALUControlE <= ALUControlD;
            flagWriteE  <= FlagWriteD;
            condE       <= CondD;
            mulE        <= MulD;
        end
    end

    // E -> M
    always_ff @(posedge clk or negedge reset) begin
        if (!reset || BusyE) begin
            RegWriteM <= 1'b0;
            MemWriteM <= 1'b0;
            MemtoRegM <= 1'b0;
            pcSrcM    <= 1'b0;
        end else begin
            RegWriteM <= regWriteEg;
            MemWriteM <= memWriteEg;
            MemtoRegM <= memtoRegE;
            pcSrcM    <= pcSrcEg;
        end
    end

    // M -> W
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            PCSrcW    <= 1'b0;
        end else begin
            RegWriteW <= RegWriteM;
            MemtoRegW <= MemtoRegM;
            PCSrcW    <= pcSrcM;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Flags <= 4'd0;
        end else if (!BusyE) begin
            if (flagWriteEg[1]) Flags[3:2] <= ALUFlags[3:2];
            if (flagWriteEg[0]) Flags[1:0] <= ALUFlags[1:0];
        end
    end

    // cnt counts the remaining held cycles after the first one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (startBusy && !FlushE) begin
                        state <= BUSY;
                        cnt   <= CNT_INIT;
                    end
                end
                BUSY: begin
                    if (FlushE) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_pipeline.sv
// Scoreboard bench: three pipelines (MUL_LAT 1, 3, 4) share one stimulus stream
// and are compared every cycle against an instruction-level reference model.
module tb_control_pipeline;

    typedef struct packed {
        logic       pcSrc, regWrite, memtoReg, memWrite, branch, aluSrc;
        logic [3:0] aluCtl;
        logic [1:0] flagWrite;
        logic [3:0] cond;
        logic       mul;
    } dT;

    typedef struct packed {
        logic       condEx, busy, branchTaken;
        logic [3:0] aluCtl;
        logic       aluSrc;
        logic [2:0] mSig;   // {RegWriteM, MemWriteM, MemtoRegM}
        logic [2:0] wSig;   // {RegWriteW, MemtoRegW, PCSrcW}
        logic [3:0] flags;
    } outT;

    typedef struct packed {
        logic regWrite, memWrite, memtoReg, pcSrc;
    } mT;

    localparam int LAT [3] = '{1, 3, 4};
    localparam logic [3:0] AL = 4'b1110;

    logic       clk = 1'b0;
    logic       reset;
    dT          d;
    logic       flushE;
    logic [3:0] aluFlags;

    logic [3:0] aluCtlE [3];
    logic [3:0] flags [3];
    logic       aluSrcE [3], condExE [3], branchTakenE [3], busyE [3];
    logic       regWriteM [3], memWriteM [3], memtoRegM [3];
    logic       regWriteW [3], memtoRegW [3], pcSrcW [3];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gDut
        control_pipeline #(
            .ALUCTRL_W(4),
            .MUL_LAT(g == 0 ? 1 : (g == 1 ? 3 : 4))
        ) dut (
            .clk(clk),
            .reset(reset),
            .PCSrcD(d.pcSrc),
            .RegWriteD(d.regWrite),
            .MemtoRegD(d.memtoReg),
            .MemWriteD(d.memWrite),
            .BranchD(d.branch),
            .ALUSrcD(d.aluSrc),
            .ALUControlD(d.aluCtl),
            .FlagWriteD(d.flagWrite),
            .CondD(d.cond),
            .MulD(d.mul),
            .FlushE(flushE),
            .ALUFlags(aluFlags),
            .ALUControlE(aluCtlE[g]),
            .ALUSrcE(aluSrcE[g]),
            .CondExE(condExE[g]),
            .BranchTakenE(branchTakenE[g]),
            .BusyE(busyE[g]),
            .RegWriteM(regWriteM[g]),
            .MemWriteM(memWriteM[g]),
            .MemtoRegM(memtoRegM[g]),
            .RegWriteW(regWriteW[g]),
            .MemtoRegW(memtoRegW[g]),
            .PCSrcW(pcSrcW[g]),
            .Flags(flags[g])
        );
    end

    // Reference model: the instruction sitting in E and how long it has been there
    dT          eInst [3];
    int         eAge [3];
    mT          mReg [3];
    mT          wReg [3];
    logic [3:0] mFlags [3];
    outT        expQ [3][$];

    // ARM encoding: cond[3:1] picks a predicate, cond[0] inverts it (except AL/NV)
    function automatic bit condOk(logic [3:0] c, logic [3:0] f);
        bit n = f[3], z = f[2], cf = f[1], v = f[0];
        bit p;
        if (c == 4'b1111) return 1'b0;
        if (c == 4'b1110) return 1'b1;
        case (c[3:1])
            3'd0: p = z;
            3'd1: p = cf;
            3'd2: p = n;
            3'd3: p = v;
            3'd4: p = cf && !z;
            3'd5: p = (n == v);
            default: p = !z && (n == v);
        endcase
        return p ^ c[0];
    endfunction

    function automatic bit holding(int i);
        return eInst[i].mul && condOk(eInst[i].cond, mFlags[i]) &&
               (LAT[i] > 1) && (eAge[i] < LAT[i] - 1);
    endfunction

    function automatic outT expOf(int i);
        outT e;
        bit c = condOk(eInst[i].cond, mFlags[i]);
        e.condEx      = c;
        e.busy        = holding(i);
        e.branchTaken = eInst[i].branch && c;
        e.aluCtl      = eInst[i].aluCtl;
        e.aluSrc      = eInst[i].aluSrc;
        e.mSig        = {mReg[i].regWrite, mReg[i].memWrite, mReg[i].memtoReg};
        e.wSig        = {wReg[i].regWrite, wReg[i].memtoReg, wReg[i].pcSrc};
        e.flags       = mFlags[i];
        return e;
    endfunction

    function automatic outT actOf(int i);
        outT a;
        a.condEx      = condExE[i];
        a.busy        = busyE[i];
        a.branchTaken = branchTakenE[i];
        a.aluCtl      = aluCtlE[i];
        a.aluSrc      = aluSrcE[i];
        a.mSig        = {regWriteM[i], memWriteM[i], memtoRegM[i]};
        a.wSig        = {regWriteW[i], memtoRegW[i], pcSrcW[i]};
        a.flags       = flags[i];
        return a;
    endfunction

    task automatic modelStep(int i, dT din, bit fl, logic [3:0] af);
        bit c = condOk(eInst[i].cond, mFlags[i]);
        bit h = holding(i);
        wReg[i] = mReg[i];
        if (h) begin
            mReg[i] = '0;
        end else begin
            mReg[i].regWrite = eInst[i].regWrite && c;
            mReg[i].memWrite = eInst[i].memWrite && c;
            mReg[i].memtoReg = eInst[i].memtoReg;
            mReg[i].pcSrc    = eInst[i].pcSrc && c;
            if (c && eInst[i].flagWrite[1]) mFlags[i][3:2] = af[3:2];
            if (c && eInst[i].flagWrite[0]) mFlags[i][1:0] = af[1:0];
        end
        if (fl) begin
            eInst[i] = '0;
            eAge[i]  = 0;
        end else if (h) begin
            eAge[i]++;
        end else begin
            eInst[i] = din;
            eAge[i]  = 0;
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 3; i++) begin
            eInst[i]  = '0;
            eAge[i]   = 0;
            mReg[i]   = '0;
            wReg[i]   = '0;
            mFlags[i] = '0;
        end
    endtask

    task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d (MUL_LAT=%0d) got=%0h want=%0h at %0t",
                     nm, i, LAT[i], act, exp, $time);
        end
    endtask

    task automatic chkZero(string nm);
        for (int i = 0; i < 3; i++) chk(nm, i, 32'(actOf(i)), 32'd0);
    endtask

    // Called at posedge+1; returns at the next posedge+1 with the model advanced
    task automatic cycle(dT din, bit fl, logic [3:0] af);
        d        = din;
        flushE   = fl;
        aluFlags = af;
        for (int i = 0; i < 3; i++) expQ[i].push_back(expOf(i));
        @(posedge clk);
        for (int i = 0; i < 3; i++) modelStep(i, din, fl, af);
        #1;
    endtask

    function automatic dT randD();
        dT r;
        r = dT'($urandom);
        r.mul = ($urandom_range(0, 2) == 0);
        return r;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (expQ[i].size() > 0) begin
                outT e, a;
                e = expQ[i].pop_front();
                a = actOf(i);
                chk("CondExE", i, 32'(a.condEx), 32'(e.condEx));
                chk("BusyE", i, 32'(a.busy), 32'(e.busy));
                chk("BranchTakenE", i, 32'(a.branchTaken), 32'(e.branchTaken));
                chk("ALUControlE", i, 32'(a.aluCtl), 32'(e.aluCtl));
                chk("ALUSrcE", i, 32'(a.aluSrc), 32'(e.aluSrc));
                chk("Mstage", i, 32'(a.mSig), 32'(e.mSig));
                chk("Wstage", i, 32'(a.wSig), 32'(e.wSig));
                chk("Flags", i, 32'(a.flags), 32'(e.flags));
            end
        end
    end

    initial begin
        dT op, z;
        z = '0;
        reset = 1'b0;
        d = '0;
        flushE = 1'b0;
        aluFlags = 4'd0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        chkZero("resetState");
        reset = 1'b1;

        // conditional suppression with Flags=0000
        op = '0;
        op.regWrite = 1'b1;
        op.cond = 4'b0000;
        cycle(op, 1'b0, 4'd0);
        repeat (3) cycle(z, 1'b0, 4'd0);
        op.cond = AL;
        cycle(op, 1'b0, 4'd0);
        repeat (2) cycle(z, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) chk("RegWriteW_AL", i, 32'(regWriteW[i]), 32'd1);
        cycle(z, 1'b0, 4'd0);

        // partial flag writes
        op = '0;
        op.flagWrite = 2'b10;
        op.cond = AL;
        cycle(op, 1'b0, 4'd0);
        op.flagWrite = 2'b01;
        cycle(op, 1'b0, 4'b1111);
        for (int i = 0; i < 3; i++) chk("FlagsNZ", i, 32'(flags[i]), 32'hC);
        cycle(z, 1'b0, 4'b0011);
        for (int i = 0; i < 3; i++) chk("FlagsCV", i, 32'(flags[i]), 32'hF);

        // branch NE with Z=1 then Z=0
        begin
            dT fw, br;
            fw = '0;
            fw.flagWrite = 2'b10;
            fw.cond = AL;
            br = '0;
            br.branch = 1'b1;
            br.cond = 4'b0001;
            cycle(fw, 1'b0, 4'd0);
            cycle(br, 1'b0, 4'b0100);
            for (int i = 0; i < 3; i++) chk("BranchNE_Z1", i, 32'(branchTakenE[i]), 32'd0);
            cycle(fw, 1'b0, 4'd0);
            cycle(br, 1'b0, 4'b0000);
            for (int i = 0; i < 3; i++) chk("BranchNE_Z0", i, 32'(branchTakenE[i]), 32'd1);
            cycle(z, 1'b0, 4'd0);
        end

        // multi-cycle op, Flags now 0011
        op = '0;
        op.mul = 1'b1;
        op.regWrite = 1'b1;
        op.cond = AL;
        cycle(op, 1'b0, 4'd0);
        chk("BusyLat1", 0, 32'(busyE[0]), 32'd0);
        chk("BusyLat3_c1", 1, 32'(busyE[1]), 32'd1);
        cycle(z, 1'b0, 4'd0);
        chk("BusyLat3_c2", 1, 32'(busyE[1]), 32'd1);
        chk("RegWriteM_bubble", 1, 32'(regWriteM[1]), 32'd0);
        cycle(z, 1'b0, 4'd0);
        chk("BusyLat3_c3", 1, 32'(busyE[1]), 32'd0);
        chk("BusyLat4_c3", 2, 32'(busyE[2]), 32'd1);
        cycle(z, 1'b0, 4'd0);
        chk("RegWriteM_mul", 1, 32'(regWriteM[1]), 32'd1);
        chk("BusyLat4_c4", 2, 32'(busyE[2]), 32'd0);
        repeat (3) cycle(z, 1'b0, 4'd0);

        // flush in the second busy cycle of a MUL_LAT=4 op that writes flags
        op.flagWrite = 2'b11;
        cycle(op, 1'b0, 4'b1100);
        cycle(z, 1'b0, 4'b1100);
        cycle(z, 1'b1, 4'b1100);
        chk("FlushBusy", 2, 32'(busyE[2]), 32'd0);
        chk("FlushFlags", 2, 32'(flags[2]), 32'h3);
        chk("FlushRegWriteM", 2, 32'(regWriteM[2]), 32'd0);
        repeat (3) cycle(z, 1'b0, 4'b1100);
        chk("FlushRegWriteW", 2, 32'(regWriteW[2]), 32'd0);

        repeat (600) cycle(randD(), ($urandom_range(0, 7) == 0), 4'($urandom));

        // asynchronous reset in mid-cycle
        d = randD();
        aluFlags = 4'($urandom);
        #3;
        reset = 1'b0;
        #1;
        chkZero("asyncReset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        modelReset();

        repeat (200) cycle(randD(), ($urandom_range(0, 7) == 0), 4'($urandom));

        #10;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
